idli_sqi_ctrl: RTL and testbench

- Sequences all traffic to the two SQI memories: the LO memory holds low nibbles and the HI memory holds high nibbles.
- Shares the memories between two requesters: instruction fetch (read-only) and data load/store.
- After reset it switches both memories into quad mode. It then runs one 16-bit word transaction at a time, driving both memories in lockstep with the same command and address, one nibble per memory per cycle.

---
 rtl/idli_sqi_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_idli_sqi_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: sequences 16-bit word transactions to a pair of SQI memories
// (LO holds low nibbles, HI holds high nibbles) driven in lockstep, and
// arbitrates the shared memories between instruction fetch and data ports.
//
// Handshake: a port's request is accepted in the cycle where vld and rdy are
// both high. rdy is combinational, is only ever high in IDLE after quad mode
// has been entered, and is high for at most one port. Requesters hold vld and
// their payload stable until rdy. Each accepted request ends with a one-cycle
// done pulse on the owning port.
module idli_sqi_ctrl #(
  parameter logic [7:0] CMD_RD   = 8'h03,
  parameter logic [7:0] CMD_WR   = 8'h02,
  parameter logic [7:0] CMD_EQIO = 8'h38
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_vld,
  input  logic [15:0] i_fetch_addr,
  output logic        o_fetch_rdy,
  output logic        o_fetch_done,
  input  logic        i_data_vld,
  input  logic        i_data_wr,
  input  logic [15:0] i_data_addr,
  input  logic [15:0] i_data_wdata,
  output logic        o_data_rdy,
  output logic        o_data_done,
  output logic [15:0] o_rdata,
  output logic        o_init_done,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic        o_sqi_oe,
  output logic [3:0]  o_sqi_lo,
  output logic [3:0]  o_sqi_hi,
  input  logic [3:0]  i_sqi_lo,
  input  logic [3:0]  i_sqi_hi
);

  // ST_RESET is held only while reset is asserted; it lets the first clock
  // after release load the first INIT cycle into the registered pins.
  typedef enum logic [3:0] {
    ST_RESET, ST_INIT, ST_INIT_GAP, ST_IDLE, ST_CMD,
    ST_ADDR, ST_DUMMY, ST_DATA, ST_GAP
  } state_t;

  state_t      state, nxt_state;
  logic [2:0]  cnt, nxt_cnt;
  logic        last_data;
  logic        t_data, t_wr;
  logic [15:0] t_addr, t_wdata;
  logic [7:0]  rd_lo_byte;
  logic        idle, grant_data, grant_fetch, accept;
  logic        n_data, n_wr;
  logic [15:0] n_addr, n_wdata;
  logic        n_cs_n, n_sck_en, n_oe;
  logic [3:0]  n_lo, n_hi;
  logic [7:0]  n_cmd;
  logic [23:0] n_a;

  // Arbitration: data wins a tie unless it won last time, so ties alternate.
  always_comb begin
    idle        = (state == ST_IDLE) && o_init_done;
    grant_data  = i_data_vld && (!i_fetch_vld || !last_data);
    grant_fetch = i_fetch_vld && !grant_data;
    o_data_rdy  = idle && grant_data;
    o_fetch_rdy = idle && grant_fetch;
    accept      = o_data_rdy || o_fetch_rdy;
    n_data      = accept ? grant_data : t_data;
    n_wr        = accept ? (grant_data && i_data_wr) : t_wr;
    n_addr      = accept ? (grant_data ? i_data_addr : i_fetch_addr) : t_addr;
    n_wdata     = accept ? i_data_wdata : t_wdata;
  end

  // Next-state and per-phase cycle counter.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 3'd1;
    case (state)
      ST_RESET:    begin nxt_state = ST_INIT; nxt_cnt = 3'd0; end
      ST_INIT:     if (cnt == 3'd7) begin nxt_state = ST_INIT_GAP; nxt_cnt = 3'd0; end
      ST_INIT_GAP: begin nxt_state = ST_IDLE; nxt_cnt = 3'd0; end
      ST_IDLE: begin
        nxt_cnt = 3'd0;
        if (accept) nxt_state = ST_CMD;
      end
      ST_CMD:      if (cnt == 3'd1) begin nxt_state = ST_ADDR; nxt_cnt = 3'd0; end
      ST_ADDR:     if (cnt == 3'd5) begin
                     nxt_state = t_wr ? ST_DATA : ST_DUMMY;
                     nxt_cnt   = 3'd0;
                   end
      ST_DUMMY:    if (cnt == 3'd1) begin nxt_state = ST_DATA; nxt_cnt = 3'd0; end
      ST_DATA:     if (cnt == 3'd1) begin nxt_state = ST_GAP; nxt_cnt = 3'd0; end
      ST_GAP:      begin nxt_state = ST_IDLE; nxt_cnt = 3'd0; end
      default:     begin nxt_state = ST_RESET; nxt_cnt = 3'd0; end
    endcase
  end

  // Pin values for the cycle about to start, so the pins can be registered.
  always_comb begin
    n_cs_n   = 1'b1;
    n_sck_en = 1'b0;
    n_oe     = 1'b0;
    n_lo     = 4'h0;
    n_hi     = 4'h0;
    n_cmd    = n_wr ? CMD_WR : CMD_RD;
    n_a      = {8'h00, n_addr};
    case (nxt_state)
      ST_INIT: begin
        n_cs_n = 1'b0; n_sck_en = 1'b1; n_oe = 1'b1;
        n_lo   = {3'b000, CMD_EQIO[3'd7 - nxt_cnt]};
        n_hi   = n_lo;
      end
      ST_CMD: begin
        n_cs_n = 1'b0; n_sck_en = 1'b1; n_oe = 1'b1;
        n_lo   = (nxt_cnt == 3'd0) ? n_cmd[7:4] : n_cmd[3:0];
        n_hi   = n_lo;
      end
      ST_ADDR: begin
        n_cs_n = 1'b0; n_sck_en = 1'b1; n_oe = 1'b1;
        case (nxt_cnt)
          3'd0:    n_lo = n_a[23:20];
          3'd1:    n_lo = n_a[19:16];
          3'd2:    n_lo = n_a[15:12];
          3'd3:    n_lo = n_a[11:8];
          3'd4:    n_lo = n_a[7:4];
          default: n_lo = n_a[3:0];
        endcase
        n_hi = n_lo;
      end
      ST_DUMMY: begin
        n_cs_n = 1'b0; n_sck_en = 1'b1;
      end
      ST_DATA: begin
        n_cs_n = 1'b0; n_sck_en = 1'b1; n_oe = n_wr;
        if (n_wr) begin
          n_lo = (nxt_cnt == 3'd0) ? n_wdata[3:0] : n_wdata[11:8];
          n_hi = (nxt_cnt == 3'd0) ? n_wdata[7:4] : n_wdata[15:12];
        end
      end
      default: ;
    endcase
  end

  // State, transaction capture and arbiter history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_RESET;
      cnt       <= 3'd0;
      last_data <= 1'b0;
      t_data    <= 1'b0;
      t_wr      <= 1'b0;
      t_addr    <= 16'h0000;
      t_wdata   <= 16'h0000;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      t_data  <= n_data;
      t_wr    <= n_wr;
      t_addr  <= n_addr;
      t_wdata <= n_wdata;
      if (accept) last_data <= grant_data;
    end
  end

  // Registered SQI pins, done pulses and init flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sqi_cs_n   <= 1'b1;
      o_sqi_sck_en <= 1'b0;
      o_sqi_oe     <= 1'b0;
      o_sqi_lo     <= 4'h0;
      o_sqi_hi     <= 4'h0;
      o_fetch_done <= 1'b0;
      o_data_done  <= 1'b0;
      o_init_done  <= 1'b0;
    end else begin
      o_sqi_cs_n   <= n_cs_n;
      o_sqi_sck_en <= n_sck_en;
      o_sqi_oe     <= n_oe;
      o_sqi_lo     <= n_lo;
      o_sqi_hi     <= n_hi;
      o_fetch_done <= (nxt_state == ST_GAP) && !t_data;
      o_data_done  <= (nxt_state == ST_GAP) && t_data;
      o_init_done  <= o_init_done || (state == ST_INIT_GAP);
    end
  end

  // Read capture: first DATA cycle holds the low byte, second completes the word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_lo_byte <= 8'h00;
      o_rdata    <= 16'h0000;
    end else if (state == ST_DATA && !t_wr) begin
      if (cnt == 3'd0) rd_lo_byte <= {i_sqi_hi, i_sqi_lo};
      else             o_rdata    <= {i_sqi_hi, i_sqi_lo, rd_lo_byte};
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Bench for idli_sqi_ctrl: directed init/fetch/store/arbitration/reset cases
// plus randomized traffic, checked cycle by cycle against a pin-level model.
module tb_idli_sqi_ctrl;

  localparam logic [7:0] EQIO = 8'h38;
  // Pin vector: {cs_n, sck_en, oe, lo[3:0], hi[3:0], fetch_done, data_done}
  localparam logic [12:0] PINS_IDLE = 13'h1000;
  localparam logic [12:0] MSK_ALL   = 13'h1FFF;
  localparam logic [12:0] MSK_RDDAT = 13'h1C03;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_vld, fetch_rdy, fetch_done;
  logic [15:0] f_addr;
  logic        data_vld, d_wr, data_rdy, data_done;
  logic [15:0] d_addr, d_wdata;
  logic [15:0] rdata;
  logic        init_done;
  logic        cs_n, sck_en, oe;
  logic [3:0]  sqo_lo, sqo_hi, sqi_lo, sqi_hi;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [12:0] exp_q[$];
  logic [12:0] msk_q[$];
  bit          m_last_data;
  logic [15:0] m_rdata;
  bit          p_f, p_d, won_d;

  idli_sqi_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_vld(fetch_vld), .i_fetch_addr(f_addr),
    .o_fetch_rdy(fetch_rdy), .o_fetch_done(fetch_done),
    .i_data_vld(data_vld), .i_data_wr(d_wr), .i_data_addr(d_addr),
    .i_data_wdata(d_wdata), .o_data_rdy(data_rdy), .o_data_done(data_done),
    .o_rdata(rdata), .o_init_done(init_done),
    .o_sqi_cs_n(cs_n), .o_sqi_sck_en(sck_en), .o_sqi_oe(oe),
    .o_sqi_lo(sqo_lo), .o_sqi_hi(sqo_hi),
    .i_sqi_lo(sqi_lo), .i_sqi_hi(sqi_hi)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] pins();
    return {cs_n, sck_en, oe, sqo_lo, sqo_hi, fetch_done, data_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: the pin sequence of one transaction, from the cycle after accept
  // up to and including the gap cycle carrying the done pulse.
  task automatic build_expect(input bit wr, input bit is_d, input logic [15:0] addr,
                              input logic [15:0] wdata);
    logic [7:0]  cmd;
    logic [23:0] a;
    logic [3:0]  nb, lo, hi;
    cmd = wr ? 8'h02 : 8'h03;
    a   = {8'h00, addr};
    for (int k = 0; k < 2; k++) begin
      nb = 4'(cmd >> (4 * (1 - k)));
      exp_q.push_back({3'b011, nb, nb, 2'b00}); msk_q.push_back(MSK_ALL);
    end
    for (int j = 0; j < 6; j++) begin
      nb = 4'(a >> (4 * (5 - j)));
      exp_q.push_back({3'b011, nb, nb, 2'b00}); msk_q.push_back(MSK_ALL);
    end
    if (!wr) begin
      for (int k = 0; k < 2; k++) begin
        exp_q.push_back({3'b010, 8'h00, 2'b00}); msk_q.push_back(MSK_ALL);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (wr) begin
        lo = 4'(wdata >> (8 * d));
        hi = 4'(wdata >> (8 * d + 4));
        exp_q.push_back({3'b011, lo, hi, 2'b00}); msk_q.push_back(MSK_ALL);
      end else begin
        exp_q.push_back({3'b010, 8'h00, 2'b00}); msk_q.push_back(MSK_RDDAT);
      end
    end
    exp_q.push_back({3'b100, 8'h00, !is_d, is_d}); msk_q.push_back(MSK_ALL);
  endtask

  // Driver: raise the requested ports, expect acceptance on the next cycle,
  // check the grant and every pin cycle of the transaction that follows.
  task automatic serve(input bit want_f, input bit want_d, input logic [15:0] rword,
                       output bit win_d);
    int          waited;
    bit          wr;
    int          len;
    logic [15:0] addr;
    logic [12:0] e, m;
    fetch_vld = want_f;
    data_vld  = want_d;
    waited    = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(fetch_rdy || data_rdy) && waited < 40);
    check("accept_latency", waited, 1);
    win_d = want_d && (!want_f || !m_last_data);
    check("grant", {fetch_rdy, data_rdy}, {!win_d, win_d});
    if (!(fetch_rdy || data_rdy)) return;
    m_last_data = win_d;
    wr   = win_d && d_wr;
    addr = win_d ? d_addr : f_addr;
    build_expect(wr, win_d, addr, d_wdata);
    len = wr ? 11 : 13;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        if (win_d) begin
          data_vld = 1'b0; d_addr = 16'($urandom);
          d_wdata = 16'($urandom); d_wr = 1'($urandom_range(0, 1));
        end else begin
          fetch_vld = 1'b0; f_addr = 16'($urandom);
        end
      end
      sqi_lo = 4'($urandom);
      sqi_hi = 4'($urandom);
      if (!wr && k == 11) begin sqi_lo = rword[3:0];  sqi_hi = rword[7:4];   end
      if (!wr && k == 12) begin sqi_lo = rword[11:8]; sqi_hi = rword[15:12]; end
      @(negedge clk);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      check("pins", pins() & m, e & m);
    end
    if (!wr) m_rdata = rword;
    check("rdata", rdata, m_rdata);
  endtask

  // Driver: after reset release, check the serial EQIO cycles and the gap.
  task automatic check_init();
    logic [7:0]  eq;
    logic        b;
    logic [12:0] e;
    eq = EQIO;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      b = 1'(eq >> (7 - k));
      e = (k < 8) ? {3'b011, 3'b000, b, 3'b000, b, 2'b00} : PINS_IDLE;
      check("init_pins", pins(), e);
      check("init_rdy", fetch_rdy, 1'b0);
      check("init_done_low", init_done, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_vld = 1'b1; f_addr = 16'h1234;
    data_vld = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    sqi_lo = 4'h0; sqi_hi = 4'h0;
    m_last_data = 1'b0; m_rdata = 16'h0000;
    p_f = 1'b0; p_d = 1'b0;

    // Reset values, with a fetch already requesting
    repeat (3) @(negedge clk);
    check("rst_pins", pins(), PINS_IDLE);
    check("rst_rdy", {fetch_rdy, data_rdy}, 2'b00);
    check("rst_init_done", init_done, 1'b0);
    check("rst_rdata", rdata, 16'h0000);

    // Release, INIT replay, then the waiting fetch is taken at cycle 9
    rst_n = 1'b1;
    check_init();
    serve(1'b1, 1'b0, 16'h8765, won_d);
    check("init_done_high", init_done, 1'b1);

    // Directed store at the top address
    d_wr = 1'b1; d_addr = 16'hFFFF; d_wdata = 16'hA5C3;
    serve(1'b0, 1'b1, 16'h0000, won_d);
    check("store_rdata_kept", rdata, 16'h8765);

    // One fetch so the next tie goes to data, then both held pending
    serve(1'b1, 1'b0, 16'($urandom), won_d);
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, 1'b1, 16'($urandom), won_d);
      check("alt_grant", won_d, (i % 2 == 0));
    end
    p_d = 1'b1;

    // Randomized traffic; a pending port stays pending until granted
    for (int i = 0; i < 10; i++) begin
      p_f = p_f | 1'($urandom_range(0, 1));
      p_d = p_d | 1'($urandom_range(0, 1));
      if (!p_f && !p_d) p_f = 1'b1;
      serve(p_f, p_d, 16'($urandom), won_d);
      if (won_d) p_d = 1'b0; else p_f = 1'b0;
    end
    while (p_f || p_d) begin
      serve(p_f, p_d, 16'($urandom), won_d);
      if (won_d) p_d = 1'b0; else p_f = 1'b0;
    end

    // Reset during the address phase of a fetch
    f_addr = 16'($urandom); fetch_vld = 1'b1; data_vld = 1'b0;
    @(negedge clk);
    check("mid_accept", fetch_rdy, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pins", pins(), PINS_IDLE);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_rdata", rdata, 16'h0000);
    m_last_data = 1'b0;
    m_rdata = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mid_rst_hold", pins(), PINS_IDLE);
    end
    rst_n = 1'b1;
    check_init();
    serve(1'b1, 1'b0, 16'($urandom), won_d);
    check("mid_refetch_owner", won_d, 1'b0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
